// File: rtl/inst_fifo.sv
// Dual-ported instruction queue between fetch and decode: up to two pushes and
// two pops per cycle, head feeds the master pipe and head+1 the slave pipe.
module inst_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              write_en1,
  input  logic              write_en2,
  input  logic [ADDR_W-1:0] write_addr1,
  input  logic [ADDR_W-1:0] write_addr2,
  input  logic [31:0]       write_inst1,
  input  logic [31:0]       write_inst2,
  input  logic              write_tlb_err1,
  input  logic              write_tlb_err2,
  input  logic              read_en1,
  input  logic              read_en2,
  output logic [ADDR_W-1:0] read_addr1,
  output logic [ADDR_W-1:0] read_addr2,
  output logic [31:0]       read_inst1,
  output logic [31:0]       read_inst2,
  output logic              read_tlb_err1,
  output logic              read_tlb_err2,
  output logic              empty,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_DM2   = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] CNT_DM1   = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [31:0]       inst_mem [DEPTH];
  logic              tlb_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PTR_W-1:0] wr_ptr_p1;
  logic [PTR_W-1:0] rd_ptr_p1;
  logic             push_one, push_two;
  logic             pop_one, pop_two;
  logic [1:0]       n_push, n_pop;

  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
  assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);

  // Acceptance uses the pre-update count only; same-cycle pops never free space.
  assign push_two = write_en1 & write_en2 & (count_q <= CNT_DM2);
  assign push_one = write_en1 & ~write_en2 & (count_q <= CNT_DM1);
  assign pop_one  = read_en1 & (count_q >= CNT_ONE);
  assign pop_two  = pop_one & read_en2 & (count_q >= CNT_TWO);

  always_comb begin
    n_push = 2'd0;
    n_pop  = 2'd0;
    if (push_two)     n_push = 2'd2;
    else if (push_one) n_push = 2'd1;
    if (pop_two)      n_pop = 2'd2;
    else if (pop_one) n_pop = 2'd1;

    wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(n_pop);
    count_d  = count_q + CNT_W'(n_push) - CNT_W'(n_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && (push_one || push_two)) begin
      addr_mem[wr_ptr_q] <= write_addr1;
      inst_mem[wr_ptr_q] <= write_inst1;
      tlb_mem[wr_ptr_q]  <= write_tlb_err1;
    end
    if (!flush && push_two) begin
      addr_mem[wr_ptr_p1] <= write_addr2;
      inst_mem[wr_ptr_p1] <= write_inst2;
      tlb_mem[wr_ptr_p1]  <= write_tlb_err2;
    end
  end

  // Invalid slots read as zero so decode never sees stale storage.
  always_comb begin
    read_addr1    = '0;
    read_inst1    = '0;
    read_tlb_err1 = 1'b0;
    read_addr2    = '0;
    read_inst2    = '0;
    read_tlb_err2 = 1'b0;
    if (count_q != CNT_ZERO) begin
      read_addr1    = addr_mem[rd_ptr_q];
      read_inst1    = inst_mem[rd_ptr_q];
      read_tlb_err1 = tlb_mem[rd_ptr_q];
    end
    if (count_q >= CNT_TWO) begin
      read_addr2    = addr_mem[rd_ptr_p1];
      read_inst2    = inst_mem[rd_ptr_p1];
      read_tlb_err2 = tlb_mem[rd_ptr_p1];
    end
  end

  assign empty        = (count_q == CNT_ZERO);
  assign almost_empty = (count_q == CNT_ONE);
  assign almost_full  = (count_q >= CNT_DM1);
  assign full         = (count_q == CNT_DEPTH);

endmodule

// File: tb/tb_inst_fifo.sv
// Directed bench for inst_fifo: dual push/pop, drops at the full boundary,
// pointer wrap, flush priority and asynchronous reset.
module tb_inst_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        write_en1, write_en2;
  logic [31:0] write_addr1, write_addr2;
  logic [31:0] write_inst1, write_inst2;
  logic        write_tlb_err1, write_tlb_err2;
  logic        read_en1, read_en2;
  logic [31:0] read_addr1, read_addr2;
  logic [31:0] read_inst1, read_inst2;
  logic        read_tlb_err1, read_tlb_err2;
  logic        empty, almost_empty, almost_full, full;

  int total = 0;
  int bad   = 0;

  inst_fifo #(.DEPTH(16), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .write_en1(write_en1), .write_en2(write_en2),
    .write_addr1(write_addr1), .write_addr2(write_addr2),
    .write_inst1(write_inst1), .write_inst2(write_inst2),
    .write_tlb_err1(write_tlb_err1), .write_tlb_err2(write_tlb_err2),
    .read_en1(read_en1), .read_en2(read_en2),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_inst1(read_inst1), .read_inst2(read_inst2),
    .read_tlb_err1(read_tlb_err1), .read_tlb_err2(read_tlb_err2),
    .empty(empty), .almost_empty(almost_empty),
    .almost_full(almost_full), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction word and TLB tag are derived from the PC so every entry is unique.
  task automatic set_w1(input logic [31:0] a);
    write_en1      = 1'b1;
    write_addr1    = a;
    write_inst1    = {16'hC0DE, a[15:0]};
    write_tlb_err1 = a[2];
  endtask

  task automatic set_w2(input logic [31:0] a);
    write_en2      = 1'b1;
    write_addr2    = a;
    write_inst2    = {16'hC0DE, a[15:0]};
    write_tlb_err2 = a[2];
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    write_en1 = 1'b0;
    write_en2 = 1'b0;
    read_en1  = 1'b0;
    read_en2  = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    write_en1 = 1'b0; write_en2 = 1'b0;
    write_addr1 = '0; write_addr2 = '0; write_inst1 = '0; write_inst2 = '0;
    write_tlb_err1 = 1'b0; write_tlb_err2 = 1'b0;
    read_en1 = 1'b0; read_en2 = 1'b0;

    #12;
    check("rst_empty", empty, 1);
    check("rst_aempty", almost_empty, 0);
    check("rst_afull", almost_full, 0);
    check("rst_full", full, 0);
    check("rst_addr1", read_addr1, 0);
    check("rst_addr2", read_addr2, 0);
    check("rst_inst1", read_inst1, 0);
    @(negedge clk); rst_n = 1'b1;

    // 2-push on empty
    set_w1(32'h1000); set_w2(32'h1004); cyc();
    check("p2_addr1", read_addr1, 32'h1000);
    check("p2_addr2", read_addr2, 32'h1004);
    check("p2_inst2", read_inst2, 32'hC0DE1004);
    check("p2_tlb1", read_tlb_err1, 0);
    check("p2_tlb2", read_tlb_err2, 1);
    check("p2_empty", empty, 0);
    check("p2_aempty", almost_empty, 0);
    read_en1 = 1'b1; read_en2 = 1'b1; cyc();
    check("pop2_empty", empty, 1);

    // single entry: read_*2 forced to zero, double pop takes only one
    set_w1(32'h2004); cyc();
    check("p1_aempty", almost_empty, 1);
    check("p1_addr1", read_addr1, 32'h2004);
    check("p1_tlb1", read_tlb_err1, 1);
    check("p1_inst2", read_inst2, 0);
    check("p1_addr2", read_addr2, 0);
    read_en1 = 1'b1; read_en2 = 1'b1; cyc();
    check("p1pop_empty", empty, 1);
    check("p1pop_aempty", almost_empty, 0);

    // fill to 15, 2-push dropped, 1-push reaches full
    for (int i = 0; i < 15; i++) begin
      set_w1(32'h3000 + 32'(4 * i)); cyc();
    end
    check("f15_afull", almost_full, 1);
    check("f15_full", full, 0);
    set_w1(32'h4000); set_w2(32'h4004); cyc();
    check("drop2_afull", almost_full, 1);
    check("drop2_full", full, 0);
    set_w1(32'h5000); cyc();
    check("f16_full", full, 1);
    // push while full is dropped even with a same-cycle pop
    set_w1(32'h6000); read_en1 = 1'b1; cyc();
    check("fpop_full", full, 0);
    check("fpop_afull", almost_full, 1);
    for (int i = 1; i <= 14; i++) begin
      check("drain", read_addr1, 64'(32'h3000 + 32'(4 * i)));
      read_en1 = 1'b1; cyc();
    end
    check("drain_last", read_addr1, 32'h5000);
    check("drain_last_ae", almost_empty, 1);
    read_en1 = 1'b1; cyc();
    check("drain_empty", empty, 1);

    // walk pointers from 3 to 15, then straddle the wrap
    for (int i = 0; i < 6; i++) begin
      set_w1(32'h6100 + 32'(8 * i)); set_w2(32'h6104 + 32'(8 * i)); cyc();
      read_en1 = 1'b1; read_en2 = 1'b1; cyc();
    end
    check("walk_empty", empty, 1);
    set_w1(32'h7000); set_w2(32'h7004); cyc();
    check("wrap_addr1", read_addr1, 32'h7000);
    check("wrap_addr2", read_addr2, 32'h7004);
    check("wrap_inst1", read_inst1, 32'hC0DE7000);
    read_en1 = 1'b1; read_en2 = 1'b1; cyc();
    check("wrap_empty", empty, 1);
    set_w1(32'h7100); cyc();
    check("wrap_rd1", read_addr1, 32'h7100);

    // count 5 with simultaneous 2-push and 1-pop
    set_w1(32'h8000); set_w2(32'h8004); cyc();
    set_w1(32'h8008); set_w2(32'h800C); cyc();
    set_w1(32'h9000); set_w2(32'h9004); read_en1 = 1'b1; cyc();
    check("mix_addr1", read_addr1, 32'h8000);
    check("mix_addr2", read_addr2, 32'h8004);
    check("mix_afull", almost_full, 0);
    read_en1 = 1'b1; read_en2 = 1'b1; cyc();
    check("mix_b_addr1", read_addr1, 32'h8008);
    check("mix_b_addr2", read_addr2, 32'h800C);
    read_en1 = 1'b1; read_en2 = 1'b1; cyc();
    check("mix_c_addr1", read_addr1, 32'h9000);
    check("mix_c_addr2", read_addr2, 32'h9004);
    read_en1 = 1'b1; read_en2 = 1'b1; cyc();
    check("mix_empty", empty, 1);

    // count 9, flush wins over push and pop
    for (int i = 0; i < 4; i++) begin
      set_w1(32'hA000 + 32'(8 * i)); set_w2(32'hA004 + 32'(8 * i)); cyc();
    end
    set_w1(32'hA040); cyc();
    check("c9_addr1", read_addr1, 32'hA000);
    flush = 1'b1; set_w1(32'hB000); set_w2(32'hB004);
    read_en1 = 1'b1; read_en2 = 1'b1; cyc();
    check("fl_empty", empty, 1);
    check("fl_addr1", read_addr1, 0);
    check("fl_addr2", read_addr2, 0);
    set_w1(32'hC000); cyc();
    check("fl_after_addr1", read_addr1, 32'hC000);
    check("fl_after_ae", almost_empty, 1);

    // write_en2 / read_en2 alone are no-ops
    set_w2(32'hD000); cyc();
    check("ill_w_ae", almost_empty, 1);
    read_en2 = 1'b1; cyc();
    check("ill_r_ae", almost_empty, 1);
    check("ill_r_addr1", read_addr1, 32'hC000);

    // asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    check("arst_empty", empty, 1);
    check("arst_addr1", read_addr1, 0);
    @(negedge clk); rst_n = 1'b1;
    cyc();
    check("arst_post_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fifo.md
Name: inst_fifo

Overview:
- Instruction queue between fetch and decode/dual-issue.
- Fetch pushes 0, 1 or 2 instructions per cycle; decode pops 0, 1 or 2 per cycle.
- Head entry feeds the master pipeline; head+1 feeds the slave pipeline.
- Produces the empty / almost_empty status used by the slave-issue check.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 4.
- ADDR_W, 32, width of the instruction address field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- flush  in  1  discard all entries (branch redirect or exception).
- write_en1  in  1  push entry 1.
- write_en2  in  1  push entry 2; legal only with write_en1.
- write_addr1  in  ADDR_W  PC of entry 1.
- write_addr2  in  ADDR_W  PC of entry 2.
- write_inst1  in  32  instruction word 1.
- write_inst2  in  32  instruction word 2.
- write_tlb_err1  in  1  fetch TLB error tag for entry 1.
- write_tlb_err2  in  1  fetch TLB error tag for entry 2.
- read_en1  in  1  pop the head (master issued).
- read_en2  in  1  pop head+1 (slave issued); legal only with read_en1.
- read_addr1  out  ADDR_W  PC at head.
- read_addr2  out  ADDR_W  PC at head+1.
- read_inst1  out  32  instruction at head.
- read_inst2  out  32  instruction at head+1.
- read_tlb_err1  out  1  TLB error tag at head.
- read_tlb_err2  out  1  TLB error tag at head+1.
- empty  out  1  count == 0.
- almost_empty  out  1  count == 1.
- almost_full  out  1  count >= DEPTH-1; fetch must stall.
- full  out  1  count == DEPTH.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count, log2(DEPTH)+1 bits.
  - Entry storage: {addr, inst, tlb_err}. Storage is not reset.
- Reset (rst_n low, asynchronous):
  - wr_ptr = rd_ptr = count = 0.
  - Outputs: empty=1, almost_empty=0, almost_full=0, full=0.
  - All read_* outputs = 0.
- Read outputs are combinational from rd_ptr and rd_ptr+1 (mod DEPTH).
  - read_*1 forced to 0 when count == 0.
  - read_*2 forced to 0 when count < 2.
- Write acceptance is decided on pre-update count:
  - A 2-entry push is accepted only if count <= DEPTH-2.
  - A 1-entry push is accepted only if count <= DEPTH-1.
  - An unaccepted push is dropped entirely; it is never partial.
  - Entry 1 goes to wr_ptr, entry 2 to wr_ptr+1. wr_ptr advances by the number accepted.
- Read acceptance is decided on pre-update count:
  - read_en1 takes effect only if count >= 1.
  - read_en2 takes effect only if count >= 2 and read_en1 takes effect.
  - rd_ptr advances by the number popped.
- Pushes and pops in the same cycle:
  - Both allowed; count_next = count + pushed - popped.
  - No write-to-read bypass: data written in cycle N is visible on read_* in cycle N+1.
  - Free space is not recomputed after same-cycle pops, so a push to a full FIFO is dropped even if a pop occurs.
- Flush has priority over everything:
  - wr_ptr, rd_ptr and count go to 0 next cycle.
  - Same-cycle writes and reads are ignored.
  - Outputs reflect empty from the next cycle.
- Illegal inputs (no assertion required):
  - write_en2 without write_en1 is treated as no write.
  - read_en2 without read_en1 is treated as no read.
- Wrap-around:
  - Pointers wrap with no gap at DEPTH-1 -> 0.
  - A 2-entry push or pop straddling the wrap is legal.
- Status flags are combinational decodes of the registered count.
- Reset deasserted mid-stream: the FIFO restarts empty. Fetch is responsible for reissuing instructions.

Test Plan:
- Reset, then 2-push of addr 0x1000/0x1004 -> next cycle count=2, read_addr1=0x1000, read_addr2=0x1004, empty=0, almost_empty=0.
- 1-push onto an empty FIFO -> almost_empty=1, read_inst2=0; a read_en1+read_en2 pop in that state pops only 1 entry, after which empty=1.
- Fill to 15 with 1-pushes, then attempt a 2-push -> dropped; count stays 15, almost_full=1. A following 1-push gives full=1, count=16.
- Pointers at 15: a 2-push places entries at indices 15 and 0; a 2-pop returns them in order, and rd_ptr wraps to 1.
- count=5 with simultaneous 2-push and 1-pop -> count=6, head advances by one, new entries appear at the tail.
- count=9 with flush asserted together with a 2-push and a 2-pop -> next cycle count=0, empty=1, and no data from the pushed entries appears.
